// File: rtl/xif_gpio.sv
// GPIO block on a MemSplit32 slave port: output set/clear/toggle, synchronised
// inputs, and edge-triggered pending bits that drive a level interrupt.
module xif_gpio #(
    parameter int unsigned GPIO_WIDTH  = 32,
    parameter logic [31:0] BASE_ADDR   = 32'h80000000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  xif_req_i,
    input  logic                  xif_we_i,
    input  logic [31:0]           xif_addr_bi,
    input  logic [3:0]            xif_be_bi,
    input  logic [31:0]           xif_wdata_bi,
    output logic                  xif_ack_o,
    output logic                  xif_resp_o,
    output logic [31:0]           xif_rdata_bo,
    input  logic [GPIO_WIDTH-1:0] gpio_bi,
    output logic [GPIO_WIDTH-1:0] gpio_bo,
    output logic                  irq_o
);
    localparam int unsigned W = GPIO_WIDTH;
    localparam logic [2:0] WARM = 3'(SYNC_STAGES + 1);

    logic                          hit, wr, rd;
    logic [2:0]                    off;
    logic [31:0]                   bmask;
    logic [W-1:0]                  wmask, wbits;
    logic [W-1:0]                  out_q, ren_q, fen_q, pend_q, prev_q, in_sync;
    logic [W-1:0]                  out_d, ren_d, fen_d, w1c, edges, rd_val;
    logic [SYNC_STAGES-1:0][W-1:0] sync_q;
    logic [2:0]                    warm_q;
    logic [31:0]                   rd_word;
    logic                          unused_ok;

    assign hit       = xif_addr_bi[31:5] == BASE_ADDR[31:5];
    assign off       = xif_addr_bi[4:2];
    assign xif_ack_o = xif_req_i & hit;
    assign wr        = xif_ack_o & xif_we_i;
    assign rd        = xif_ack_o & ~xif_we_i;
    assign bmask     = {{8{xif_be_bi[3]}}, {8{xif_be_bi[2]}}, {8{xif_be_bi[1]}}, {8{xif_be_bi[0]}}};
    assign wmask     = bmask[W-1:0];
    assign wbits     = xif_wdata_bi[W-1:0] & wmask;
    assign unused_ok = ^{xif_addr_bi[1:0], xif_wdata_bi, bmask};

    assign in_sync = sync_q[SYNC_STAGES-1];
    assign gpio_bo = out_q;

    // Edges are ignored until the synchroniser and prev flop hold real pin data.
    assign edges = (warm_q == 3'd0) ?
                   ((in_sync & ~prev_q & ren_q) | (~in_sync & prev_q & fen_q)) : '0;

    always_comb begin
        out_d = out_q;
        ren_d = ren_q;
        fen_d = fen_q;
        w1c   = '0;
        if (wr) begin
            case (off)
                3'd0:    out_d = (out_q & ~wmask) | wbits;
                3'd2:    out_d = out_q | wbits;
                3'd3:    out_d = out_q & ~wbits;
                3'd4:    out_d = out_q ^ wbits;
                3'd5:    ren_d = (ren_q & ~wmask) | wbits;
                3'd6:    fen_d = (fen_q & ~wmask) | wbits;
                3'd7:    w1c   = wbits;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_val = '0;
        case (off)
            3'd0:    rd_val = out_q;
            3'd1:    rd_val = in_sync;
            3'd5:    rd_val = ren_q;
            3'd6:    rd_val = fen_q;
            3'd7:    rd_val = pend_q;
            default: rd_val = '0;
        endcase
        rd_word        = '0;
        rd_word[W-1:0] = rd_val;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q        <= '0;
            ren_q        <= '0;
            fen_q        <= '0;
            pend_q       <= '0;
            prev_q       <= '0;
            sync_q       <= '0;
            warm_q       <= WARM;
            irq_o        <= 1'b0;
            xif_resp_o   <= 1'b0;
            xif_rdata_bo <= '0;
        end else begin
            out_q        <= out_d;
            ren_q        <= ren_d;
            fen_q        <= fen_d;
            sync_q       <= {sync_q[SYNC_STAGES-2:0], gpio_bi};
            prev_q       <= in_sync;
            if (warm_q != 3'd0)
                warm_q <= warm_q - 3'd1;
            // Set beats clear when an edge and a W1C land together.
            pend_q       <= (pend_q & ~w1c) | edges;
            irq_o        <= |pend_q;
            xif_resp_o   <= rd;
            xif_rdata_bo <= rd ? rd_word : '0;
        end
    end
endmodule

// File: tb/tb_xif_gpio.sv
// Randomised plus directed bench for xif_gpio; read responses are checked by a
// queue-based scoreboard against a history-based behavioural model.
module tb_xif_gpio;
    localparam int          GW    = 24;
    localparam int          S     = 2;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam logic [31:0] WMASK = 32'h00FF_FFFF;

    logic          clk = 1'b0;
    logic          rst, req, we;
    logic [31:0]   addr, wdata;
    logic [3:0]    be;
    logic [GW-1:0] gpio_in;
    logic          ack, resp, irq;
    logic [31:0]   rdata;
    logic [GW-1:0] gpio_out;

    always #5 clk = ~clk;

    xif_gpio #(.GPIO_WIDTH(GW), .BASE_ADDR(BASE), .SYNC_STAGES(S)) dut (
        .clk_i(clk), .rst_i(rst),
        .xif_req_i(req), .xif_we_i(we), .xif_addr_bi(addr), .xif_be_bi(be), .xif_wdata_bi(wdata),
        .xif_ack_o(ack), .xif_resp_o(resp), .xif_rdata_bo(rdata),
        .gpio_bi(gpio_in), .gpio_bo(gpio_out), .irq_o(irq)
    );

    typedef struct { logic [31:0] data; int cyc; } exp_t;
    exp_t        expq[$];
    exp_t        mon_e;
    int          n_vec = 0, n_err = 0, cyc = 0, warm = 0;
    bit          mon_en = 1'b0;
    logic [31:0] m_out = '0, m_ren = '0, m_fen = '0, m_pend = '0;
    logic        m_irq = 1'b0;
    logic [31:0] hist[$];   // hist[j] = pin value captured j posedges ago

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic model_step();
        logic [31:0] in_at, prv, m, d, w1c, edges, ren0, fen0, pend0, rv;
        in_at = hist[S-1];
        prv   = hist[S];
        if (rst) begin
            m_out = '0; m_ren = '0; m_fen = '0; m_pend = '0; m_irq = 1'b0;
            hist = {};
            repeat (S + 1) hist.push_back('0);
            warm = 0;
        end else begin
            warm++;
            ren0 = m_ren; fen0 = m_fen; pend0 = m_pend; w1c = '0;
            if (req && addr[31:5] == BASE[31:5]) begin
                m = '0;
                for (int i = 0; i < 4; i++) if (be[i]) m |= 32'hFF << (8 * i);
                m &= WMASK;
                d = wdata & m;
                if (!we) begin
                    case (addr[4:2])
                        3'd0:    rv = m_out;
                        3'd1:    rv = in_at;
                        3'd5:    rv = ren0;
                        3'd6:    rv = fen0;
                        3'd7:    rv = pend0;
                        default: rv = '0;
                    endcase
                    expq.push_back('{rv, cyc + 1});
                end else begin
                    case (addr[4:2])
                        3'd0:    m_out = (m_out & ~m) | d;
                        3'd2:    m_out = m_out | d;
                        3'd3:    m_out = m_out & ~d;
                        3'd4:    m_out = m_out ^ d;
                        3'd5:    m_ren = (m_ren & ~m) | d;
                        3'd6:    m_fen = (m_fen & ~m) | d;
                        3'd7:    w1c = d;
                        default: ;
                    endcase
                end
            end
            edges  = (warm > S + 1) ? ((in_at & ~prv & ren0) | (~in_at & prv & fen0)) : '0;
            m_pend = (pend0 & ~w1c) | edges;
            m_irq  = |pend0;
            hist.push_front(32'(gpio_in));
            void'(hist.pop_back());
        end
    endtask

    task automatic drive(bit r, bit q, bit w, logic [31:0] a, logic [3:0] b, logic [31:0] d);
        rst = r; req = q; we = w; addr = a; be = b; wdata = d;
        #1;
        check("ack", 32'(ack), 32'(q && a[31:5] == BASE[31:5]));
        @(posedge clk);
        model_step();
        cyc++;
        mon_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic wr(int o, logic [31:0] d, logic [3:0] b = 4'hF);
        drive(0, 1, 1, BASE + 32'(4 * o), b, d);
    endtask
    task automatic rd(int o);
        drive(0, 1, 0, BASE + 32'(4 * o), 4'hF, 32'h0);
    endtask
    task automatic idle(int n = 1);
        repeat (n) drive(0, 0, 0, 32'h0, 4'h0, 32'h0);
    endtask
    task automatic reset(int n);
        repeat (n) drive(1, 0, 0, 32'h0, 4'h0, 32'h0);
    endtask

    // Scoreboard monitor: every cycle checks outputs against the model and pops
    // the expected read response when the DUT presents one.
    always @(negedge clk) begin
        if (mon_en) begin
            check("gpio_bo", 32'(gpio_out), m_out);
            check("irq_o", 32'(irq), 32'(m_irq));
            if (resp) begin
                if (expq.size() == 0) begin
                    check("resp_unexpected", 32'(resp), 32'h0);
                end else begin
                    mon_e = expq.pop_front();
                    check("rdata", rdata, mon_e.data);
                    check("resp_cycle", cyc, mon_e.cyc);
                end
            end else begin
                check("rdata_idle", rdata, 32'h0);
                if (expq.size() != 0 && expq[0].cyc <= cyc) begin
                    check("resp_missing", 32'(resp), 32'h1);
                    void'(expq.pop_front());
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        gpio_in = '0;
        repeat (S + 1) hist.push_back('0);
        reset(3);
        idle(4);
        // output set/clear/toggle sequence
        wr(0, 32'h0000_00F0); wr(2, 32'h01); wr(3, 32'h10); wr(4, 32'h03); idle();
        // byte enables and upper-bit masking
        wr(0, 32'h0); wr(0, 32'hAABB_CCDD, 4'b0101); rd(0); idle();
        wr(0, 32'hFFFF_FFFF); rd(0); idle();
        // input synchroniser
        gpio_in = 24'h05; idle(3); rd(1); idle();
        // rise pending, W1C, fall without FALL_EN
        gpio_in = '0; idle(4);
        wr(5, 32'h1); wr(6, 32'h0);
        gpio_in = 24'h1; idle(4); rd(7);
        gpio_in = '0; idle(4); rd(7);
        wr(7, 32'h1); idle(); rd(7); idle(2);
        // pin high through reset, then edge coinciding with W1C
        gpio_in = 24'h1; reset(2); wr(5, 32'h1); idle(5); rd(7);
        gpio_in = '0; idle(4); gpio_in = 24'h1; idle(4); rd(7);
        gpio_in = '0; idle(4); gpio_in = 24'h1; idle(2); wr(7, 32'h1); idle(); rd(7);
        // disabling RISE_EN keeps pending bits
        wr(5, 32'h0); rd(7); idle();
        // window miss and write-only offsets
        drive(0, 1, 1, BASE + 32'h20, 4'hF, 32'hFFFF_FFFF);
        drive(0, 1, 0, BASE + 32'h20, 4'hF, 32'h0);
        rd(2); rd(3); rd(4); idle();
        // back-to-back reads, then reset right after a read and while reading/writing
        rd(0); rd(1); rd(5); rd(6); rd(7);
        rd(0); drive(1, 1, 0, BASE, 4'hF, 32'h0); drive(1, 1, 1, BASE, 4'hF, 32'h5A5A5A);
        idle(5);
        // randomised traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) gpio_in = gpio_in ^ 24'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) gpio_in = 24'($urandom);
            case ($urandom_range(0, 9))
                8:       a = BASE + 32'h20 + 32'(4 * $urandom_range(0, 7));
                9:       a = $urandom;
                default: a = BASE + 32'(4 * $urandom_range(0, 7));
            endcase
            drive($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                  a, 4'($urandom), $urandom);
        end
        idle(3);
        check("queue_drain", 32'(expq.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
